// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the waveform-capture controller.
//   cap_state_t : controller state encoding
//   RD_LAT      : read latency of ram_dual (registered address, then registered data)
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } cap_state_t;

  localparam int RD_LAT = 2;

endpackage

// File: rtl/ram_dual.sv
// ram_dual: simple dual-port sample RAM, one write port and one read port.
// Read path has two register stages: the read address is registered, then the
// data word is registered, so out reflects addr_out from two edges earlier.
//   clk      : clock
//   we       : write enable for addr_in/in
//   addr_in  : write address
//   in       : write data
//   addr_out : read address
//   out      : registered read data
module ram_dual #(
  parameter int MEMSIZE   = 1024,
  parameter int SIGSIZE   = 16,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr_in,
  input  logic [SIGSIZE-1:0]   in,
  input  logic [ADDRWIDTH-1:0] addr_out,
  output logic [SIGSIZE-1:0]   out
);

  logic [SIGSIZE-1:0]   mem [MEMSIZE];
  logic [ADDRWIDTH-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_in] <= in;
    end
    raddr_q <= addr_out;
    out     <= mem[raddr_q];
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: triggered waveform-capture sequencer around a ram_dual buffer.
// Records din continuously into a circular buffer, keeps PRETRIG samples of
// history before the trigger, completes the post-trigger record, then streams
// the whole MEMSIZE-sample record out oldest-first on request.
//   clk, rst    : clock, synchronous active-high reset
//   arm         : start a capture (IDLE/DONE only)
//   trig        : trigger level, sampled in ARMED with din_valid
//   din         : sample, din_valid qualifies it
//   rd_start    : start readout (DONE only; arm takes priority)
//   dout        : readout sample, qualified by dout_valid
//   dout_last   : final readout sample
//   busy, done  : status flags
//   trig_addr   : RAM address of the trigger sample
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int MEMSIZE   = 1024,
  parameter int SIGSIZE   = 16,
  parameter int ADDRWIDTH = 10,
  parameter int PRETRIG   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [SIGSIZE-1:0]   din,
  input  logic                 din_valid,
  input  logic                 rd_start,
  output logic [SIGSIZE-1:0]   dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRWIDTH-1:0] trig_addr
);

  localparam int CNT_W = ADDRWIDTH + 1;

  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = ADDRWIDTH'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     PRE_CNT  = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0]     POST_CNT = CNT_W'(MEMSIZE - PRETRIG);
  localparam logic [CNT_W-1:0]     MEM_CNT  = CNT_W'(MEMSIZE);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(MEMSIZE - 1);
  // Last READ cycle: all issues done and the RAM pipeline has drained.
  localparam logic [CNT_W-1:0]     RD_END   = CNT_W'(MEMSIZE + RD_LAT - 1);

  cap_state_t           state_q, state_d;
  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;        // pre-count in PRE, post-count in POST
  logic [CNT_W-1:0]     rd_idx_q, rd_idx_d;
  logic [ADDRWIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                 busy_q, done_q;

  logic                 issue;
  logic                 last_issue;
  logic                 we;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [SIGSIZE-1:0]   ram_out;
  logic                 vld_p1, vld_p2;
  logic                 last_p1, last_p2;

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    trig_addr_d = trig_addr_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = PRE;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      PRE: begin
        if (din_valid) begin
          wr_ptr_d = wr_ptr_q + ADDR_ONE;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_d == PRE_CNT) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (din_valid) begin
          wr_ptr_d = wr_ptr_q + ADDR_ONE;
          if (trig) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = CNT_ONE;
            // Trigger sample alone may complete the post record.
            state_d     = (POST_CNT == CNT_ONE) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (din_valid) begin
          wr_ptr_d = wr_ptr_q + ADDR_ONE;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_d == POST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (arm) begin
          state_d  = PRE;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end else if (rd_start) begin
          state_d  = READ;
          rd_idx_d = '0;
        end
      end
      READ: begin
        rd_idx_d = rd_idx_q + CNT_ONE;
        if (rd_idx_q == RD_END) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port and read-issue decode. wr_ptr points at the oldest sample once
  // the record is complete, so the readout starts there.
  assign we         = din_valid && (state_q inside {PRE, ARMED, POST});
  assign issue      = (state_q == READ) && (rd_idx_q < MEM_CNT);
  assign last_issue = issue && (rd_idx_q == LAST_IDX);
  assign rd_ptr     = wr_ptr_q + rd_idx_q[ADDRWIDTH-1:0];

  ram_dual #(
    .MEMSIZE  (MEMSIZE),
    .SIGSIZE  (SIGSIZE),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .addr_in (wr_ptr_q),
    .in      (din),
    .addr_out(rd_ptr),
    .out     (ram_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      last_p1     <= 1'b0;
      last_p2     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= state_d inside {PRE, ARMED, POST, READ};
      done_q      <= (state_d == DONE);
      // Stage p1: RAM has registered the read address.
      vld_p1      <= issue;
      last_p1     <= last_issue;
      // Stage p2: RAM has registered the read data.
      vld_p2      <= vld_p1;
      last_p2     <= last_p1;
    end
  end

  // dout is forced to zero outside valid beats so reset leaves it at 0.
  assign dout       = vld_p2 ? ram_out : '0;
  assign dout_valid = vld_p2;
  assign dout_last  = last_p2;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with MEMSIZE=16, PRETRIG=4.
module tb_capture_ctrl;

  localparam int MEMSIZE   = 16;
  localparam int SIGSIZE   = 16;
  localparam int ADDRWIDTH = 4;
  localparam int PRETRIG   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 arm;
  logic                 trig;
  logic [SIGSIZE-1:0]   din;
  logic                 din_valid;
  logic                 rd_start;
  logic [SIGSIZE-1:0]   dout;
  logic                 dout_valid;
  logic                 dout_last;
  logic                 busy;
  logic                 done;
  logic [ADDRWIDTH-1:0] trig_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  capture_ctrl #(
    .MEMSIZE  (MEMSIZE),
    .SIGSIZE  (SIGSIZE),
    .ADDRWIDTH(ADDRWIDTH),
    .PRETRIG  (PRETRIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig      (trig),
    .din       (din),
    .din_valid (din_valid),
    .rd_start  (rd_start),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Arm, feed a ramp until done (bounded), then check sample count and trig_addr.
  // In gapped mode every other cycle has din_valid=0 with junk din and trig=1.
  task automatic do_capture(input string tag, input int trig_at, input bit trig_always,
                            input bit gapped, input int exp_n, input int exp_taddr);
    int v   = 0;
    int cyc = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk({tag, "_busy_after_arm"}, 32'(busy), 32'd1);
    while (!done && cyc < 400) begin
      if (gapped && cyc[0]) begin
        din_valid = 1'b0;
        din       = 16'hDEAD;
        trig      = 1'b1;
      end else begin
        din_valid = 1'b1;
        din       = 16'(v);
        trig      = trig_always || (v == trig_at);
        v++;
      end
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    trig      = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_samples_to_done"}, 32'(v), 32'(exp_n));
    chk({tag, "_trig_addr"}, 32'(trig_addr), 32'(exp_taddr));
  endtask

  // Pulse rd_start and observe 40 edges; optionally pulse arm mid-readout.
  task automatic do_read(input string tag, input int first, input bit arm_mid);
    int got        = 0;
    int first_edge = -1;
    rd_start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      rd_start = 1'b0;
      arm      = arm_mid && (e == 5);
      if (dout_valid) begin
        if (first_edge < 0) first_edge = e;
        chk({tag, "_dout"}, 32'(dout), 32'(first + got));
        chk({tag, "_last"}, 32'(dout_last), 32'(got == MEMSIZE - 1));
        got++;
      end
    end
    arm = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(MEMSIZE));
    chk({tag, "_latency"}, 32'(first_edge), 32'd3);
    chk({tag, "_done_after"}, 32'(done), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int got;
    int seen;
    rst       = 1'b1;
    arm       = 1'b0;
    trig      = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    rd_start  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_last", 32'(dout_last), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    rst = 1'b0;
    tick();

    // rd_start in IDLE does nothing
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("idle_rdstart_busy", 32'(busy), 32'd0);

    // Basic capture: trigger at 10, record 6..21
    do_capture("basic", 10, 1'b0, 1'b0, 22, 10);
    do_read("basic_rd", 6, 1'b0);

    // Record readable again; arm during READ is ignored
    do_read("reread_arm", 6, 1'b1);

    // Early trigger: trig held high, taken on din=4
    do_capture("early", -1, 1'b1, 1'b0, 16, 4);
    do_read("early_rd", 0, 1'b0);

    // Gapped input
    do_capture("gapped", 10, 1'b0, 1'b1, 22, 10);
    do_read("gapped_rd", 6, 1'b0);

    // Wrap-around: trigger at 44
    do_capture("wrap", 44, 1'b0, 1'b0, 56, 12);
    do_read("wrap_rd", 40, 1'b0);

    // arm + rd_start together in DONE: arm wins
    arm      = 1'b1;
    rd_start = 1'b1;
    tick();
    arm      = 1'b0;
    rd_start = 1'b0;
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_done", 32'(done), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dout_valid) seen++;
    end
    chk("prio_no_dout", 32'(seen), 32'd0);
    do_capture("prio", 10, 1'b0, 1'b0, 22, 10);

    // Reset at the 5th readout sample
    got = 0;
    rd_start = 1'b1;
    for (int e = 1; e <= 40 && got < 5; e++) begin
      tick();
      rd_start = 1'b0;
      if (dout_valid) got++;
    end
    chk("rstmid_reached5", 32'(got), 32'd5);
    rst = 1'b1;
    tick();
    chk("rstmid_dout_valid", 32'(dout_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_trig_addr", 32'(trig_addr), 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dout_valid) seen++;
    end
    chk("rstmid_no_tail", 32'(seen), 32'd0);
    chk("rstmid_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
